stream_to_axi_writer: RTL and testbench

//  Companion to the AXI-to-stream path, working in the opposite direction.
//  - Accepts AXI4-Stream beats and packs them into AXI4 INCR write bursts.
//  - Bursts go to a circular buffer region in memory.
//  - Sits between a stream source (Ethernet RX side) and the memory-mapped fabric.
//  - Write-only AXI4 master; buffers one burst internally before issuing the address.

---
 rtl/stream_to_axi_writer.sv | 199 +++++++++++++++++++
 tb/tb_stream_to_axi_writer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_to_axi_writer.sv
// stream_to_axi_writer: packs AXI4-Stream beats into AXI4 INCR write bursts
// aimed at consecutive slots of a circular buffer. One burst is buffered
// before its address is issued, and only one burst is ever outstanding.
module stream_to_axi_writer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    BURST_LEN  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}},
  parameter int                    RING_BYTES = 4096
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [31:0]             burst_cnt,
  output logic                    pkt_done,
  output logic                    err
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int SLOT_BYTES = BURST_LEN * STRB_W;
  localparam int CNT_W      = $clog2(BURST_LEN + 1);
  localparam int PTR_W      = $clog2(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] SLOT_INC = ADDR_WIDTH'(SLOT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] RING_END = BASE_ADDR + ADDR_WIDTH'(RING_BYTES);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic                    tlast_q, tlast_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]             burst_cnt_q, burst_cnt_d;
  logic                    err_q, err_d;
  logic                    pkt_done_q, pkt_done_d;

  logic [DATA_WIDTH-1:0]   data_mem_q [BURST_LEN];
  logic [STRB_W-1:0]       keep_mem_q [BURST_LEN];

  logic                    beat_acc_s;
  logic                    last_beat_s;
  logic [CNT_W-1:0]        count_m1_s;
  logic [ADDR_WIDTH-1:0]   addr_inc_s;

  assign s_axis_tready = (state_q == S_FILL) && (count_q < CNT_FULL);
  assign beat_acc_s    = s_axis_tvalid && s_axis_tready;
  assign count_m1_s    = count_q - CNT_W'(1);
  assign last_beat_s   = (rd_ptr_q == PTR_W'(count_m1_s));
  // Every burst consumes a whole slot, so the ring advances by SLOT even for short bursts.
  assign addr_inc_s    = wr_addr_q + SLOT_INC;

  assign m_axi_awvalid = (state_q == S_ADDR);
  assign m_axi_awaddr  = wr_addr_q;
  assign m_axi_awlen   = 8'(count_m1_s);
  assign m_axi_awsize  = 3'($clog2(STRB_W));
  assign m_axi_awburst = 2'b01;
  assign m_axi_wvalid  = (state_q == S_DATA);
  assign m_axi_wdata   = data_mem_q[rd_ptr_q];
  assign m_axi_wstrb   = keep_mem_q[rd_ptr_q];
  assign m_axi_wlast   = last_beat_s;
  assign m_axi_bready  = (state_q == S_RESP);
  assign wr_addr       = wr_addr_q;
  assign burst_cnt     = burst_cnt_q;
  assign pkt_done      = pkt_done_q;
  assign err           = err_q;

  // Burst buffer: store each accepted beat at the current fill index.
  always_ff @(posedge aclk) begin
    if (beat_acc_s) begin
      data_mem_q[count_q[PTR_W-1:0]] <= s_axis_tdata;
      keep_mem_q[count_q[PTR_W-1:0]] <= s_axis_tkeep;
    end
  end

  // State and bookkeeping registers; reset abandons any burst in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      count_q     <= {CNT_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      tlast_q     <= 1'b0;
      wr_addr_q   <= BASE_ADDR;
      burst_cnt_q <= 32'd0;
      err_q       <= 1'b0;
      pkt_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      tlast_q     <= tlast_d;
      wr_addr_q   <= wr_addr_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
      pkt_done_q  <= pkt_done_d;
    end
  end

  // Next-state logic: fill buffer, issue address, drain data, collect response.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    tlast_d     = tlast_q;
    wr_addr_d   = wr_addr_q;
    burst_cnt_d = burst_cnt_q;
    err_d       = err_q;
    pkt_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (beat_acc_s) begin
          count_d = count_q + CNT_W'(1);
          tlast_d = s_axis_tlast;
          // Leaving on the accept cycle gives awvalid one cycle after the last beat.
          if (s_axis_tlast || (count_q == CNT_LAST)) begin
            state_d = S_ADDR;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_ADDR: begin
        if (m_axi_awready) begin
          state_d  = S_DATA;
          rd_ptr_d = {PTR_W{1'b0}};
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (m_axi_wready) begin
          if (last_beat_s) begin
            state_d  = S_RESP;
            rd_ptr_d = {PTR_W{1'b0}};
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_RESP: begin
        if (m_axi_bvalid) begin
          burst_cnt_d = burst_cnt_q + 32'd1;
          err_d       = err_q | (m_axi_bresp != 2'b00);
          pkt_done_d  = tlast_q;
          count_d     = {CNT_W{1'b0}};
          tlast_d     = 1'b0;
          if (addr_inc_s == RING_END) begin
            wr_addr_d = BASE_ADDR;
          end else begin
            wr_addr_d = addr_inc_s;
          end
          if (enable) begin
            state_d = S_FILL;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stream_to_axi_writer.sv
// tb_stream_to_axi_writer: randomized stream source and AXI slave around the
// writer, with a reference model that groups accepted beats into expected bursts.
module tb_stream_to_axi_writer;

  localparam int          BL   = 4;
  localparam int          SLOT = 16;
  localparam logic [31:0] BASE = 32'h1000;

  typedef struct packed {logic [31:0] data; logic [3:0] keep; logic last;} beat_t;
  typedef struct packed {logic [31:0] addr; logic [7:0] len;} aw_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] s_axis_tdata = 32'd0;
  logic [3:0]  s_axis_tkeep = 4'd0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic [31:0] wr_addr;
  logic [31:0] burst_cnt;
  logic        pkt_done;
  logic        err;

  stream_to_axi_writer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LEN(BL),
    .BASE_ADDR(32'h1000), .RING_BYTES(64)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .wr_addr(wr_addr), .burst_cnt(burst_cnt), .pkt_done(pkt_done), .err(err)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // source, model and observation state
  beat_t src_q[$], cur[$], exp_w[$], w_obs[$];
  aw_t   exp_aw[$], aw_obs[$];
  logic [1:0] bresp_plan[$];
  int nb, exp_pkt, pkt_obs, b_pending;
  bit exp_err, tv_busy, b_busy, lat_pending, aw_prev_pend, w_prev_pend, w_toggle;
  int stab_viol, conc_viol, lat_viol, attr_viol, tready_cnt;
  int tv_pct = 100, aw_pct = 100, w_pct = 100, b_pct = 100, en_pct = 0;
  aw_t   aw_prev;
  beat_t w_prev;

  function automatic bit chance(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  function automatic int w_diff();
    int d;
    d = (w_obs.size() > exp_w.size()) ? w_obs.size() - exp_w.size() : exp_w.size() - w_obs.size();
    for (int i = 0; i < w_obs.size() && i < exp_w.size(); i++)
      if (w_obs[i] !== exp_w[i]) d++;
    return d;
  endfunction

  function automatic int aw_diff();
    int d;
    d = (aw_obs.size() > exp_aw.size()) ? aw_obs.size() - exp_aw.size() : exp_aw.size() - aw_obs.size();
    for (int i = 0; i < aw_obs.size() && i < exp_aw.size(); i++)
      if (aw_obs[i] !== exp_aw[i]) d++;
    return d;
  endfunction

  // reference model: a burst closes on tlast or after BL beats and takes the next ring slot
  function automatic void model_accept(input beat_t b);
    aw_t a;
    beat_t e;
    cur.push_back(b);
    if (b.last || cur.size() == BL) begin
      a.addr = BASE + 32'((nb % 4) * SLOT);
      a.len  = 8'(cur.size() - 1);
      exp_aw.push_back(a);
      foreach (cur[i]) begin
        e = cur[i];
        e.last = (i == cur.size() - 1);
        exp_w.push_back(e);
      end
      if (b.last) exp_pkt++;
      nb++;
      cur.delete();
      lat_pending = 1'b1;
    end
  endfunction

  task automatic clear_obs();
    aw_obs.delete(); w_obs.delete(); exp_aw.delete(); exp_w.delete();
    exp_pkt = 0; pkt_obs = 0; stab_viol = 0; conc_viol = 0; lat_viol = 0;
    attr_viol = 0; tready_cnt = 0;
  endtask

  // one clock: drive inputs at negedge, observe handshakes just before the posedge
  task automatic step();
    beat_t b;
    aw_t a;
    @(negedge aclk);
    enable = chance(en_pct);
    if (!tv_busy) begin
      if (src_q.size() > 0 && chance(tv_pct)) begin
        {s_axis_tdata, s_axis_tkeep, s_axis_tlast} = src_q[0];
        s_axis_tvalid = 1'b1;
        tv_busy = 1'b1;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata = $urandom;
      end
    end
    m_axi_awready = chance(aw_pct);
    m_axi_wready  = w_toggle ? !m_axi_wready : chance(w_pct);
    if (!b_busy) begin
      if (b_pending > 0 && chance(b_pct)) begin
        m_axi_bresp = (bresp_plan.size() > 0) ? bresp_plan.pop_front() : 2'b00;
        if (m_axi_bresp != 2'b00) exp_err = 1'b1;
        m_axi_bvalid = 1'b1;
        b_busy = 1'b1;
      end else begin
        m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'($urandom);
      end
    end
    #4;
    if (lat_pending && m_axi_awvalid !== 1'b1) lat_viol++;
    lat_pending = 1'b0;
    if (aw_prev_pend && (m_axi_awvalid !== 1'b1 || {m_axi_awaddr, m_axi_awlen} !== aw_prev)) stab_viol++;
    if (w_prev_pend && (m_axi_wvalid !== 1'b1 || {m_axi_wdata, m_axi_wstrb, m_axi_wlast} !== w_prev)) stab_viol++;
    aw_prev_pend = m_axi_awvalid && !m_axi_awready;
    aw_prev = {m_axi_awaddr, m_axi_awlen};
    w_prev_pend = m_axi_wvalid && !m_axi_wready;
    w_prev = {m_axi_wdata, m_axi_wstrb, m_axi_wlast};
    if (m_axi_awvalid && (m_axi_awsize !== 3'd2 || m_axi_awburst !== 2'b01)) attr_viol++;
    if ((m_axi_awvalid && m_axi_wvalid) || ((m_axi_awvalid || m_axi_wvalid) && m_axi_bready) ||
        (s_axis_tready && (m_axi_awvalid || m_axi_wvalid || m_axi_bready))) conc_viol++;
    if (s_axis_tready === 1'b1) tready_cnt++;
    if (pkt_done === 1'b1) pkt_obs++;
    if (m_axi_awvalid && m_axi_awready) begin
      a.addr = m_axi_awaddr; a.len = m_axi_awlen;
      aw_obs.push_back(a);
    end
    if (m_axi_wvalid && m_axi_wready) begin
      w_obs.push_back({m_axi_wdata, m_axi_wstrb, m_axi_wlast});
      if (m_axi_wlast) b_pending++;
    end
    if (m_axi_bvalid && m_axi_bready) begin
      b_busy = 1'b0;
      b_pending--;
    end
    if (s_axis_tvalid && s_axis_tready) begin
      b = src_q.pop_front();
      tv_busy = 1'b0;
      model_accept(b);
    end
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while (!(src_q.size() == 0 && cur.size() == 0 && b_pending == 0 && !b_busy &&
             aw_obs.size() == exp_aw.size() && w_obs.size() == exp_w.size()) && n < 3000) begin
      step();
      n++;
    end
    ok = (n < 3000);
    repeat (3) step();
  endtask

  task automatic do_reset(input int en);
    aresetn = 1'b0;
    enable = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = 32'd0; s_axis_tkeep = 4'd0;
    s_axis_tlast = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    src_q.delete(); cur.delete(); bresp_plan.delete(); clear_obs();
    nb = 0; exp_err = 1'b0; b_pending = 0; tv_busy = 1'b0; b_busy = 1'b0;
    lat_pending = 1'b0; aw_prev_pend = 1'b0; w_prev_pend = 1'b0; w_toggle = 1'b0;
    tv_pct = 100; aw_pct = 100; w_pct = 100; b_pct = 100; en_pct = en;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #1;
  endtask

  task automatic push_beats(input int n, input logic [31:0] d0, input bit rnd, input bit last_end);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = rnd ? $urandom : d0 + 32'(i);
      b.keep = rnd ? 4'($urandom_range(1, 15)) : 4'hF;
      b.last = last_end && (i == n - 1);
      src_q.push_back(b);
    end
  endtask

  task automatic test_reset();
    do_reset(0);
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready, pkt_done} !== 5'b0) begin
      failures++; $display("FAIL reset_valids: got %b expected 00000",
        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready, pkt_done});
    end
    checks++;
    if (wr_addr !== 32'h1000) begin failures++; $display("FAIL reset_wr_addr: got %h expected 00001000", wr_addr); end
    checks++;
    if (burst_cnt !== 32'd0) begin failures++; $display("FAIL reset_burst_cnt: got %0d expected 0", burst_cnt); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_single_burst();
    bit ok;
    clear_obs(); en_pct = 100;
    push_beats(4, 32'hA0, 1'b0, 1'b1);
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout: got timeout expected completion"); end
    checks++;
    if (aw_obs.size() != 1 || aw_obs[0] !== {32'h1000, 8'd3}) begin
      failures++; $display("FAIL single_aw: got n=%0d first=%h expected 1 burst 00001000/03", aw_obs.size(),
        aw_obs.size() > 0 ? aw_obs[0] : 40'h0);
    end
    checks++;
    if (attr_viol != 0) begin failures++; $display("FAIL single_awsize_burst: got %0d bad cycles expected 0", attr_viol); end
    checks++;
    if (w_diff() != 0 || w_obs.size() != 4 || w_obs[3] !== {32'hA3, 4'hF, 1'b1}) begin
      failures++; $display("FAIL single_w: got %0d diffs over %0d beats expected 0 over 4", w_diff(), w_obs.size());
    end
    checks++;
    if (pkt_obs != 1) begin failures++; $display("FAIL single_pkt_done: got %0d pulse cycles expected 1", pkt_obs); end
    checks++;
    if (burst_cnt !== 32'd1 || wr_addr !== 32'h1010) begin
      failures++; $display("FAIL single_cnt_addr: got %0d/%h expected 1/00001010", burst_cnt, wr_addr);
    end
    checks++;
    if (lat_viol != 0) begin failures++; $display("FAIL single_latency: got %0d late awvalid expected 0", lat_viol); end
  endtask

  task automatic test_short_burst();
    bit ok;
    clear_obs();
    push_beats(2, 32'hB0, 1'b0, 1'b1);
    drain(ok);
    checks++;
    if (!ok || aw_obs.size() != 1 || aw_obs[0] !== {32'h1010, 8'd1}) begin
      failures++; $display("FAIL short_aw: got n=%0d ok=%0d expected 1 burst 00001010/01", aw_obs.size(), ok);
    end
    checks++;
    if (w_diff() != 0 || w_obs.size() != 2 || w_obs[1].last !== 1'b1) begin
      failures++; $display("FAIL short_w: got %0d diffs over %0d beats expected 0 over 2", w_diff(), w_obs.size());
    end
    checks++;
    if (pkt_obs != 1 || wr_addr !== 32'h1020) begin
      failures++; $display("FAIL short_pkt_addr: got %0d/%h expected 1/00001020", pkt_obs, wr_addr);
    end
  endtask

  task automatic test_ring_wrap();
    bit ok;
    logic [31:0] exp_addr [5];
    int bad = 0;
    exp_addr = '{32'h1000, 32'h1010, 32'h1020, 32'h1030, 32'h1000};
    do_reset(100);
    push_beats(20, 32'h0, 1'b1, 1'b0);
    drain(ok);
    for (int i = 0; i < 5; i++)
      if (i >= aw_obs.size() || aw_obs[i] !== {exp_addr[i], 8'd3}) bad++;
    checks++;
    if (!ok || bad != 0 || aw_obs.size() != 5) begin
      failures++; $display("FAIL ring_awaddr: got %0d wrong of %0d bursts expected 0 of 5", bad, aw_obs.size());
    end
    checks++;
    if (burst_cnt !== 32'd5 || pkt_obs != 0) begin
      failures++; $display("FAIL ring_cnt: got %0d bursts %0d pkt expected 5 bursts 0 pkt", burst_cnt, pkt_obs);
    end
    checks++;
    if (w_diff() != 0 || wr_addr !== 32'h1010) begin
      failures++; $display("FAIL ring_w_addr: got %0d diffs addr %h expected 0 diffs 00001010", w_diff(), wr_addr);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int n = 0, held = 0;
    clear_obs(); aw_pct = 0;
    push_beats(4, 32'h0, 1'b1, 1'b0);
    push_beats(3, 32'h0, 1'b1, 1'b1);
    while (m_axi_awvalid !== 1'b1 && n < 50) begin step(); n++; end
    for (int i = 0; i < 7; i++) begin
      step();
      if (m_axi_awvalid === 1'b1 && s_axis_tready === 1'b0 && m_axi_wvalid === 1'b0) held++;
    end
    checks++;
    if (held != 7) begin failures++; $display("FAIL stall_aw_hold: got %0d held cycles expected 7", held); end
    aw_pct = 100; w_toggle = 1'b1;
    drain(ok);
    w_toggle = 1'b0;
    checks++;
    if (!ok || stab_viol != 0 || conc_viol != 0) begin
      failures++; $display("FAIL stall_stable: got ok=%0d stab=%0d conc=%0d expected 1/0/0", ok, stab_viol, conc_viol);
    end
    checks++;
    if (w_diff() != 0 || aw_diff() != 0) begin
      failures++; $display("FAIL stall_data: got %0d w diffs %0d aw diffs expected 0/0", w_diff(), aw_diff());
    end
  endtask

  task automatic test_enable_hold();
    bit ok;
    do_reset(0);
    push_beats(3, 32'hC0, 1'b0, 1'b1);
    repeat (10) step();
    checks++;
    if (tready_cnt != 0 || src_q.size() != 3) begin
      failures++; $display("FAIL enable_hold: got tready=%0d cycles %0d left expected 0 cycles 3 left", tready_cnt, src_q.size());
    end
    en_pct = 100;
    drain(ok);
    checks++;
    if (!ok || w_diff() != 0 || aw_obs.size() != 1 || aw_obs[0] !== {32'h1000, 8'd2}) begin
      failures++; $display("FAIL enable_resume: got ok=%0d %0d diffs %0d bursts expected 1/0/1", ok, w_diff(), aw_obs.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 4; it++) begin
      clear_obs();
      tv_pct = $urandom_range(30, 100); aw_pct = $urandom_range(30, 100);
      w_pct = $urandom_range(30, 100); b_pct = $urandom_range(30, 100); en_pct = $urandom_range(40, 100);
      for (int k = 0; k < 25; k++) begin
        push_beats(1, 32'h0, 1'b1, ($urandom_range(3) == 0) || (k == 24));
      end
      drain(ok);
      checks++;
      if (!ok || aw_diff() != 0 || w_diff() != 0) begin
        failures++; $display("FAIL random_%0d_stream: got ok=%0d aw=%0d w=%0d diffs expected 1/0/0", it, ok, aw_diff(), w_diff());
      end
      checks++;
      if (pkt_obs != exp_pkt || stab_viol + conc_viol + lat_viol + attr_viol != 0) begin
        failures++; $display("FAIL random_%0d_proto: got pkt=%0d viol=%0d expected pkt=%0d viol=0", it, pkt_obs,
          stab_viol + conc_viol + lat_viol + attr_viol, exp_pkt);
      end
      checks++;
      if (burst_cnt !== 32'(nb) || wr_addr !== BASE + 32'((nb % 4) * SLOT)) begin
        failures++; $display("FAIL random_%0d_cnt_addr: got %0d/%h expected %0d/%h", it, burst_cnt, wr_addr,
          nb, BASE + 32'((nb % 4) * SLOT));
      end
    end
    tv_pct = 100; aw_pct = 100; w_pct = 100; b_pct = 100; en_pct = 100;
  endtask

  task automatic test_bresp_err();
    bit ok;
    do_reset(100);
    bresp_plan.push_back(2'b10);
    bresp_plan.push_back(2'b00);
    push_beats(8, 32'h0, 1'b1, 1'b0);
    drain(ok);
    checks++;
    if (!ok || err !== 1'b1 || err !== exp_err) begin
      failures++; $display("FAIL bresp_err: got ok=%0d err=%b expected 1/1", ok, err);
    end
    checks++;
    if (burst_cnt !== 32'd2) begin failures++; $display("FAIL bresp_cnt: got %0d expected 2", burst_cnt); end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int n = 0;
    clear_obs();
    push_beats(4, 32'h0, 1'b1, 1'b1);
    while (w_obs.size() < 1 && n < 50) begin step(); n++; end
    w_pct = 0;
    step();
    checks++;
    if (m_axi_wvalid !== 1'b1 || w_obs.size() != 1) begin
      failures++; $display("FAIL midrst_pre: got wvalid=%b beats=%0d expected 1/1", m_axi_wvalid, w_obs.size());
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready} !== 4'b0) begin
      failures++; $display("FAIL midrst_valids: got %b expected 0000",
        {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready});
    end
    do_reset(100);
    checks++;
    if (wr_addr !== 32'h1000 || burst_cnt !== 32'd0 || err !== 1'b0) begin
      failures++; $display("FAIL midrst_state: got %h/%0d/%b expected 00001000/0/0", wr_addr, burst_cnt, err);
    end
    push_beats(4, 32'h0, 1'b1, 1'b1);
    drain(ok);
    checks++;
    if (!ok || aw_diff() != 0 || w_diff() != 0 || burst_cnt !== 32'd1) begin
      failures++; $display("FAIL midrst_resume: got ok=%0d aw=%0d w=%0d cnt=%0d expected 1/0/0/1", ok, aw_diff(), w_diff(), burst_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_short_burst();
    test_ring_wrap();
    test_stall();
    test_enable_hold();
    test_random();
    test_bresp_err();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
